// File: rtl/inv_round_key_sched.sv
`default_nettype none
// ============================================================================
// inv_round_key_sched : AES-128 round-key sequencer; drives an external
// key-step forward, banks keys 0..NR, serves them NR..0. Option: KEY_ZEROIZE_EN
// Revision: 1.0
// ============================================================================
module inv_round_key_sched #(
  parameter int NR      = 10,
  parameter int RD_WRAP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef KEY_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic [127:0] kg_prev_key,
  output logic [31:0]  kg_rcon,
  input  logic [127:0] kg_next_key,
  output logic         keys_valid,
  input  logic         rd_restart,
  input  logic         rd_next,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;
  localparam logic [3:0] IDX_LAST  = 4'(NR);

  logic [1:0]             state_q, state_d;
  logic [NR:0][127:0]     bank_q, bank_d;
  logic [7:0]             rc_q, rc_d;
  logic [3:0]             round_q, round_d;
  logic [3:0]             rk_idx_q, rk_idx_d;
  logic [127:0]           rk_out_q, rk_out_d;
  logic                   zero_now;
  logic                   in_expand;

`ifdef KEY_ZEROIZE_EN
  assign zero_now = zeroize;
`else
  assign zero_now = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    rc_d     = rc_q;
    round_d  = round_q;
    rk_idx_d = rk_idx_q;
    if (zero_now) begin
      state_d  = ST_IDLE;
      bank_d   = '0;
      rc_d     = '0;
      round_d  = '0;
      rk_idx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            bank_d[0] = key_in;
            round_d   = 4'd1;
            rc_d      = 8'h01;
            state_d   = ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          bank_d[round_q] = kg_next_key;
          rc_d            = xtime(rc_q);
          round_d         = round_q + 4'd1;
          if (round_q == IDX_LAST) begin
            state_d  = ST_READY;
            round_d  = '0;
            rk_idx_d = IDX_LAST;
          end
        end
        ST_READY: begin
          // A new key wins over any read request in the same cycle.
          if (key_valid) begin
            bank_d[0] = key_in;
            round_d   = 4'd1;
            rc_d      = 8'h01;
            state_d   = ST_EXPAND;
          end else if (rd_restart) begin
            rk_idx_d = IDX_LAST;
          end else if (rd_next) begin
            if (rk_idx_q != 4'd0)
              rk_idx_d = rk_idx_q - 4'd1;
            else
              rk_idx_d = (RD_WRAP != 0) ? IDX_LAST : 4'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Look up with next-state values so rk_out lands together with rk_idx.
    rk_out_d = bank_d[rk_idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bank_q   <= '0;
      rc_q     <= 8'h01;
      round_q  <= '0;
      rk_idx_q <= '0;
      rk_out_q <= '0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      rc_q     <= rc_d;
      round_q  <= round_d;
      rk_idx_q <= rk_idx_d;
      rk_out_q <= rk_out_d;
    end
  end

  assign in_expand   = (state_q == ST_EXPAND);
  assign key_ready   = !in_expand;
  assign keys_valid  = (state_q == ST_READY);
  assign kg_prev_key = in_expand ? bank_q[round_q - 4'd1] : '0;
  assign kg_rcon     = in_expand ? {rc_q, 24'h000000} : '0;
  assign rk_out      = rk_out_q;
  assign rk_idx      = rk_idx_q;
  assign rk_last     = keys_valid && (rk_idx_q == 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_inv_round_key_sched.sv
`default_nettype none
// ============================================================================
// tb_inv_round_key_sched : directed bench with an AES-128 key-step model.
// Revision: 1.0
// ============================================================================
module tb_inv_round_key_sched;

  localparam int RD_WRAP_TB = 1;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         zeroize = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key_in = '0;
  logic [127:0] kg_prev_key;
  logic [31:0]  kg_rcon;
  logic [127:0] kg_next_key;
  logic         keys_valid;
  logic         rd_restart = 1'b0;
  logic         rd_next = 1'b0;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rc_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  inv_round_key_sched #(.NR(10), .RD_WRAP(RD_WRAP_TB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef KEY_ZEROIZE_EN
    .zeroize     (zeroize),
`endif
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_in      (key_in),
    .kg_prev_key (kg_prev_key),
    .kg_rcon     (kg_rcon),
    .kg_next_key (kg_next_key),
    .keys_valid  (keys_valid),
    .rd_restart  (rd_restart),
    .rd_next     (rd_next),
    .rk_out      (rk_out),
    .rk_idx      (rk_idx),
    .rk_last     (rk_last)
  );

  always #5 clk = ~clk;

  // Combinational AES-128 key-step: one round of the FIPS-197 expansion.
  function automatic logic [127:0] key_step(input logic [127:0] p, input logic [31:0] rcon);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = p[127:96];
    w1 = p[95:64];
    w2 = p[63:32];
    w3 = p[31:0];
    t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ rcon;
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign kg_next_key = key_step(kg_prev_key, kg_rcon);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_key(input logic [127:0] k);
    key_valid = 1'b1;
    key_in    = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic pulse_next();
    rd_next = 1'b1;
    tick();
    rd_next = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_key_ready"},  128'(key_ready),  128'd1);
    check({pfx, "_keys_valid"}, 128'(keys_valid), 128'd0);
    check({pfx, "_rk_last"},    128'(rk_last),    128'd0);
    check({pfx, "_prev_key"},   kg_prev_key,      128'd0);
    check({pfx, "_rcon"},       128'(kg_rcon),    128'd0);
    check({pfx, "_rk_out"},     rk_out,           128'd0);
    check({pfx, "_rk_idx"},     128'(rk_idx),     128'd0);
  endtask

  initial begin
    #2;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Forward expansion of the FIPS-197 example key.
    accept_key(K1);
    check("exp_key_ready", 128'(key_ready), 128'd0);
    check("exp_prev_key0", kg_prev_key, K1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("exp_rcon_%0d", i), 128'(kg_rcon), 128'({rc_exp[i], 24'h000000}));
      check($sformatf("exp_kv_low_%0d", i), 128'(keys_valid), 128'd0);
      tick();
    end
    check("exp_keys_valid", 128'(keys_valid), 128'd1);
    check("exp_rk_idx",     128'(rk_idx),     128'd10);
    check("exp_rk_out10",   rk_out,           K1_R10);
    check("exp_rcon_ready", 128'(kg_rcon),    128'd0);

    // Reverse read down to key 0, then one more pulse.
    for (int s = 1; s <= 10; s++) begin
      pulse_next();
      check($sformatf("rd_idx_%0d", s), 128'(rk_idx), 128'(10 - s));
      if (s == 1) begin
        check("rd_key9", rk_out, K1_R9);
        check("rd_last_lo", 128'(rk_last), 128'd0);
      end
      if (s == 9) check("rd_key1", rk_out, K1_R1);
      if (s == 10) begin
        check("rd_key0", rk_out, K1);
        check("rd_last_hi", 128'(rk_last), 128'd1);
      end
    end
    pulse_next();
    check("rd_wrap_idx", 128'(rk_idx), 128'((RD_WRAP_TB != 0) ? 10 : 0));

    // rd_restart beats rd_next.
    rd_restart = 1'b1;
    tick();
    rd_restart = 1'b0;
    repeat (6) pulse_next();
    check("prio_idx4", 128'(rk_idx), 128'd4);
    rd_restart = 1'b1;
    rd_next    = 1'b1;
    tick();
    rd_restart = 1'b0;
    rd_next    = 1'b0;
    check("prio_idx10", 128'(rk_idx), 128'd10);
    check("prio_key10", rk_out, K1_R10);

    // Reload a new key from READY with a read request in the same cycle.
    repeat (7) pulse_next();
    check("reload_idx3", 128'(rk_idx), 128'd3);
    rd_next = 1'b1;
    accept_key(K2);
    rd_next = 1'b0;
    check("reload_kv_drop", 128'(keys_valid), 128'd0);
    check("reload_ready",   128'(key_ready),  128'd0);
    check("reload_idx_hold", 128'(rk_idx),    128'd3);
    repeat (10) tick();
    check("reload_kv",    128'(keys_valid), 128'd1);
    check("reload_key10", rk_out, K2_R10);

    // Asynchronous reset in the middle of an expansion.
    accept_key(K1);
    repeat (4) tick();
    check("rst_mid_rcon", 128'(kg_rcon), 128'h10000000);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();
    accept_key(K1);
    repeat (10) tick();
    check("rst_fresh_kv",    128'(keys_valid), 128'd1);
    check("rst_fresh_key10", rk_out, K1_R10);
    pulse_next();
    check("rst_fresh_key9", rk_out, K1_R9);

`ifdef KEY_ZEROIZE_EN
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check("zero_kv",     128'(keys_valid), 128'd0);
    check("zero_ready",  128'(key_ready),  128'd1);
    check("zero_rk_out", rk_out,           128'd0);
    check("zero_rk_idx", 128'(rk_idx),     128'd0);
    accept_key(K2);
    check("zero_reentry_out", rk_out, K2);
    repeat (10) tick();
    check("zero_reentry_key10", rk_out, K2_R10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inv_round_key_sched.md
Name: inv_round_key_sched

Overview:
- Sequencer directly upstream of the team's combinational single-round AES-128 key-step.
- Accepts a 128-bit cipher key and walks the key-step forward one round per cycle.
- Stores round keys 0..10 in an internal key bank.
- Serves the keys in reverse order (10 down to 0) to the inverse-cipher datapath.

Parameters:
- NR, 10, number of rounds; only 10 is legal (AES-128).
- RD_WRAP, 1, read pointer behaviour at key 0: 1 = rd_next wraps to NR, 0 = saturates at 0.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  cipher key presented
- key_ready  out  1  block can accept a key
- key_in  in  128  cipher key, bits [0:127], column-major, byte 0 = bits [0:7]
- kg_prev_key  out  128  previous round key to key-step
- kg_rcon  out  32  round constant to key-step: {rc, 24'h000000}
- kg_next_key  in  128  next round key returned combinationally by key-step
- keys_valid  out  1  key bank complete, rk_out meaningful
- rd_restart  in  1  set read pointer to NR
- rd_next  in  1  advance read pointer one key toward key 0
- rk_out  out  128  round key at read pointer (registered bank output)
- rk_idx  out  4  current read pointer
- rk_last  out  1  rk_idx == 0 and keys_valid

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - state IDLE; all 11 bank slots 0; rc = 8'h01; round counter 0; rk_idx 0.
  - key_ready 1; keys_valid 0; rk_last 0; kg_prev_key 0; kg_rcon 0; rk_out 0.
- States: IDLE, EXPAND, READY.
- IDLE:
  - key_ready = 1.
  - On key_valid & key_ready: slot0 <= key_in; round <= 1; rc <= 8'h01; go to EXPAND.
- EXPAND:
  - key_ready = 0; key_valid is ignored.
  - kg_prev_key = slot[round-1]; kg_rcon = {rc, 24'h0}.
  - Each cycle: slot[round] <= kg_next_key; rc <= xtime(rc); round <= round+1.
  - xtime(rc) = {rc[6:0],1'b0} ^ (rc[7] ? 8'h1B : 8'h00).
  - rc sequence: 01 02 04 08 10 20 40 80 1B 36.
  - The write of round 10 moves to READY and sets rk_idx <= 10.
- Latency: keys_valid rises exactly 10 cycles after the key-accept edge.
- In IDLE and READY, kg_prev_key and kg_rcon are driven to 0.
- READY:
  - keys_valid = 1; key_ready = 1.
  - rk_out = slot[rk_idx], registered so it tracks rk_idx with no extra delay.
  - rd_restart has priority over rd_next: rk_idx <= 10.
  - rd_next at rk_idx > 0: rk_idx <= rk_idx-1.
  - rd_next at rk_idx == 0: rk_idx <= 10 if RD_WRAP, else it holds at 0.
- New key while in READY (key_valid & key_ready):
  - Go to EXPAND and overwrite the bank.
  - keys_valid drops on the next edge.
  - rd_restart / rd_next in that same cycle are ignored.
- rd_restart / rd_next outside READY: ignored.
- rst_n asserted mid-EXPAND: immediate return to reset values; a partially written bank is discarded (zeroed).

Optional Feature:
- Macro: KEY_ZEROIZE_EN.
- When defined:
  - Adds input port zeroize (1 bit).
  - When high on a clock edge: all slots, rk_out, rk_idx and rc are cleared in that cycle and state goes to IDLE.
  - zeroize takes priority over key acceptance and reads, in any state.
- When undefined:
  - No port.
  - Keys persist until overwritten or reset.

Test Plan:
- Bench binds kg_next_key to the team's key-step model.
- Expansion check:
  - Stimulus: key_in = 2b7e151628aed2a6abf7158809cf4f3c.
  - kg_rcon[0:7] must be 01,02,...,1B,36 on consecutive cycles.
  - keys_valid must be high on cycle 10 after accept.
  - rk_idx = 10; rk_out = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reverse read:
  - From READY, 10 rd_next pulses.
  - Step 1: rk_out = ac7766f319fadc2128d12941575c006e (key 9).
  - Step 10: rk_out = 2b7e1516...4f3c; rk_last = 1.
  - Pulse 11: rk_idx = 10 with RD_WRAP = 1; rk_idx = 0 with RD_WRAP = 0.
- Priority: rd_restart and rd_next together at rk_idx = 4 -> rk_idx = 10.
- Reload:
  - key_valid with key 000102...0f while in READY at rk_idx = 3.
  - keys_valid is 0 on the next cycle.
  - After 10 cycles: rk_out = 13111d7fe3944a17f307a78b4d2b30c5.
- Reset mid-EXPAND:
  - rst_n low at round 5 -> all outputs return to reset values asynchronously.
  - Then a fresh key expands correctly.
- Zeroize (KEY_ZEROIZE_EN):
  - zeroize pulse in READY -> next cycle state IDLE, keys_valid = 0.
  - After re-entry via a new key, no stale keys are observable at rk_out.
